// File: rtl/ram_port_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_master_if
//  Brief    : Request / response stream bundle between a client and
//             ram_port_master.
//  Revision : 1.0
// ============================================================================
interface ram_port_master_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH/8-1:0]   req_wstrb;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_WIDTH-1:0]     resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wstrb, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wstrb, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_master.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_master
//  Brief    : Valid/ready initiator for the fixed-latency RAM port with
//             credit-managed response FIFO and read-after-write stalling.
//  Revision : 1.0
// ============================================================================
module ram_port_master #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int READ_DELAY  = 1,
    parameter int WRITE_DELAY = 1,
    parameter int RESP_DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    ram_port_master_if.slave         bus,
    output logic [ADDR_WIDTH-1:0]    ram_raddr,
    output logic [ADDR_WIDTH-1:0]    ram_waddr,
    output logic [DATA_WIDTH/8-1:0]  ram_wstrb,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     idle
);
    localparam int c_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RESP_DEPTH + 1);

    logic                    w_raw_hit;
    logic                    w_rd_ok;
    logic                    w_acc;
    logic                    w_acc_rd;
    logic                    w_acc_wr;
    logic                    w_push;
    logic                    w_pop;

    logic [c_CNT_W-1:0]      r_credit;
    logic [c_CNT_W-1:0]      r_fifo_cnt;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_fifo [RESP_DEPTH];
    logic [READ_DELAY:0]     r_rvs;
    logic [WRITE_DELAY-1:0]  r_trk_valid;
    logic [ADDR_WIDTH-1:0]   r_trk_addr [WRITE_DELAY];

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A read must wait while any not-yet-committed write targets its address.
    always_comb begin
        w_raw_hit = 1'b0;
        for (int i = 0; i < WRITE_DELAY; i++) begin
            if (r_trk_valid[i] && (r_trk_addr[i] == bus.req_addr)) begin
                w_raw_hit = 1'b1;
            end
        end
    end

    assign w_rd_ok        = (r_credit < c_CNT_W'(RESP_DEPTH)) && !w_raw_hit;
    assign bus.req_ready  = !reset && (bus.req_write || w_rd_ok);
    assign w_acc          = bus.req_valid && bus.req_ready;
    assign w_acc_rd       = w_acc && !bus.req_write;
    assign w_acc_wr       = w_acc && bus.req_write;
    assign w_push         = r_rvs[READ_DELAY];
    assign bus.resp_valid = (r_fifo_cnt != '0);
    assign w_pop          = bus.resp_valid && bus.resp_ready;
    assign bus.resp_rdata = r_fifo[r_rd_ptr];
    assign idle           = (r_credit == '0) && !(|r_trk_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_raddr <= '0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_wstrb <= '0;
        end else begin
            ram_wstrb <= w_acc_wr ? bus.req_wstrb : '0;
            if (w_acc_wr) begin
                ram_waddr <= bus.req_addr;
                ram_wdata <= bus.req_wdata;
            end
            if (w_acc_rd) begin
                ram_raddr <= bus.req_addr;
            end
        end
    end

    // Entry 0 mirrors the write on the port this cycle; older entries age out.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvs       <= '0;
            r_trk_valid <= '0;
            for (int i = 0; i < WRITE_DELAY; i++) begin
                r_trk_addr[i] <= '0;
            end
        end else begin
            r_rvs          <= {r_rvs[READ_DELAY-1:0], w_acc_rd};
            r_trk_valid[0] <= w_acc_wr && (|bus.req_wstrb);
            r_trk_addr[0]  <= bus.req_addr;
            for (int i = 1; i < WRITE_DELAY; i++) begin
                r_trk_valid[i] <= r_trk_valid[i-1];
                r_trk_addr[i]  <= r_trk_addr[i-1];
            end
        end
    end

    // Credits cover in-flight reads plus FIFO occupancy, so the FIFO never overflows.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_credit   <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case ({w_acc_rd, w_pop})
                2'b10:   r_credit <= r_credit + 1'b1;
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= ram_rdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ram_port_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_master
//  Brief    : Randomized and directed bench for ram_port_master with a
//             fixed-latency RAM model and an in-order architectural memory.
//  Revision : 1.0
// ============================================================================
module tb_ram_port_master;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int RD    = 1;
    localparam int WD    = 2;
    localparam int DEPTH = 4;
    localparam int CI    = (WD > 1) ? WD - 2 : 0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_port_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic [AW-1:0] ram_raddr;
    logic [AW-1:0] ram_waddr;
    logic [SW-1:0] ram_wstrb;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          idle;

    ram_port_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_DELAY(RD),
        .WRITE_DELAY(WD), .RESP_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wstrb(ram_wstrb),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .idle(idle)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        return (a < 16) ? DW'(a) : (DW'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Fixed-latency RAM: reads return after RD cycles, writes visible WD cycles after the port cycle.
    logic          preload = 1'b1;
    logic [DW-1:0] mem   [0:(1<<AW)-1];
    logic [DW-1:0] rpipe [RD];
    logic [AW-1:0] wq_a  [WD];
    logic [SW-1:0] wq_s  [WD];
    logic [DW-1:0] wq_d  [WD];
    assign ram_rdata = rpipe[RD-1];

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
            for (int i = 0; i < RD; i++) rpipe[i] <= '0;
            for (int i = 0; i < WD; i++) wq_s[i] <= '0;
        end else begin
            rpipe[0] <= mem[ram_raddr];
            for (int i = 1; i < RD; i++) rpipe[i] <= rpipe[i-1];
            wq_a[0] <= ram_waddr;
            wq_s[0] <= ram_wstrb;
            wq_d[0] <= ram_wdata;
            for (int i = 1; i < WD; i++) begin
                wq_a[i] <= wq_a[i-1];
                wq_s[i] <= wq_s[i-1];
                wq_d[i] <= wq_d[i-1];
            end
            if (WD == 1) mem[ram_waddr] <= merge(mem[ram_waddr], ram_wdata, ram_wstrb);
            else         mem[wq_a[CI]]  <= merge(mem[wq_a[CI]], wq_d[CI], wq_s[CI]);
        end
    end

    // Architectural model: requests take effect in acceptance order.
    logic [DW-1:0] shadow [int];
    logic [DW-1:0] exp_q [$];
    int            pop_cyc_q [$];
    int            n_rd  = 0;
    int            n_pop = 0;

    function automatic logic [DW-1:0] model_rd(input int a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    int  rr_mode = 0;
    logic rr_rand = 1'b1;
    always @(posedge clock) rr_rand <= 1'($urandom);
    assign bus.resp_ready = (rr_mode == 0) || ((rr_mode == 2) && rr_rand);

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_write) begin
                    shadow[int'(bus.req_addr)] = merge(model_rd(int'(bus.req_addr)), bus.req_wdata, bus.req_wstrb);
                end else begin
                    exp_q.push_back(model_rd(int'(bus.req_addr)));
                    n_rd++;
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                n_pop++;
                pop_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) chk("spurious_resp", 1, 0);
                else                   chk("resp_rdata", bus.resp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input int a, input logic [SW-1:0] s,
                         input logic [DW-1:0] d, output int acc);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = AW'(a);
        bus.req_wstrb = s;
        bus.req_wdata = d;
        acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            @(negedge clock);
            if (bus.req_ready) acc = cyc;
            tick();
        end
        bus.req_valid = 1'b0;
        if (acc < 0) chk("issue_timeout", 0, 1);
    endtask

    task automatic wait_resp(output int rc);
        rc = -1;
        for (int i = 0; i < 100 && rc < 0; i++) begin
            @(negedge clock);
            if (bus.resp_valid) rc = cyc;
        end
        if (rc < 0) chk("resp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 300 && ok == 0; i++) begin
            @(negedge clock);
            if (idle) ok = 1;
        end
        chk("idle_reached", ok, 1);
        chk("drain_queue_empty", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wa, ra, rc, nacc, rd0, pop0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = '0;
        bus.req_wstrb = '0;
        bus.req_wdata = '0;
        repeat (3) tick();
        preload = 1'b0;

        @(negedge clock);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_ram_wstrb", ram_wstrb, 0);
        chk("rst_ram_raddr", ram_raddr, 0);
        chk("rst_ram_waddr", ram_waddr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_idle", idle, 1);
        tick();
        bus.req_valid = 1'b0;
        reset = 1'b0;

        // Read directly behind a write to the same address
        issue(1'b1, 'h010, 4'hF, 32'hDEADBEEF, wa);
        issue(1'b0, 'h010, '0, '0, ra);
        chk("raw_stall_cycles", ra - wa - 1, WD);
        wait_resp(rc);
        chk("read_latency", rc - ra, RD + 2);
        chk("raw_data", bus.resp_rdata, 32'hDEADBEEF);
        tick();
        wait_idle();

        // Byte-merged partial write
        issue(1'b1, 'h020, 4'hF, 32'hAABBCCDD, wa);
        issue(1'b1, 'h020, 4'h5, 32'h11223344, wa);
        issue(1'b0, 'h020, '0, '0, ra);
        wait_resp(rc);
        chk("strobe_merge", bus.resp_rdata, 32'hAA22CC44);
        tick();
        wait_idle();

        // Different address is not held back; same address waits WD cycles
        issue(1'b1, 5, 4'hF, 32'h55555555, wa);
        issue(1'b0, 6, '0, '0, ra);
        chk("no_stall_other_addr", ra - wa - 1, 0);
        wait_idle();
        issue(1'b1, 5, 4'hF, 32'h0A0B0C0D, wa);
        issue(1'b0, 5, '0, '0, ra);
        chk("raw_stall_same_addr", ra - wa - 1, WD);
        wait_idle();

        // Back-to-back stream with the consumer always ready
        pop_cyc_q.delete();
        for (int a = 0; a < 16; a++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = AW'(a);
            @(negedge clock);
            chk("stream_ready", bus.req_ready, 1);
            tick();
        end
        bus.req_valid = 1'b0;
        wait_idle();
        chk("stream_resp_count", pop_cyc_q.size(), 16);
        if (pop_cyc_q.size() == 16) chk("stream_one_per_cycle", pop_cyc_q[15] - pop_cyc_q[0], 15);

        // Same stream with the consumer stalled for 10 cycles
        pop_cyc_q.delete();
        rr_mode = 1;
        nacc    = 0;
        for (int k = 0; k < 10; k++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = AW'(nacc);
            @(negedge clock);
            if (k == 9) chk("bp_ready_low", bus.req_ready, 0);
            if (bus.req_ready) nacc++;
            tick();
        end
        bus.req_valid = 1'b0;
        chk("bp_accepted", nacc, DEPTH);
        @(negedge clock);
        chk("bp_resp_valid_held", bus.resp_valid, 1);
        chk("bp_head_data", bus.resp_rdata, 0);
        tick();
        rr_mode = 0;
        for (int a = nacc; a < 16; a++) issue(1'b0, a, '0, '0, ra);
        wait_idle();
        chk("bp_resp_count", pop_cyc_q.size(), 16);

        // Reset with reads in flight
        rr_mode = 1;
        for (int a = 0; a < 3; a++) issue(1'b0, 'h30 + a, '0, '0, ra);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rr_mode = 0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = AW'('h40);
        @(negedge clock);
        chk("post_rst_resp_valid", bus.resp_valid, 0);
        chk("post_rst_idle", idle, 1);
        chk("post_rst_ready", bus.req_ready, 1);
        ra = cyc;
        tick();
        bus.req_valid = 1'b0;
        wait_resp(rc);
        chk("post_rst_latency", rc - ra, RD + 2);
        chk("post_rst_data", bus.resp_rdata, init_val('h40));
        tick();
        wait_idle();

        // Randomized mix with hazards on a small address window and random backpressure
        rr_mode = 2;
        rd0  = n_rd;
        pop0 = n_pop;
        for (int n = 0; n < 400; n++) begin
            issue(1'($urandom), int'($urandom_range(0, 7)), SW'($urandom), DW'($urandom), ra);
            repeat ($urandom_range(0, 2)) tick();
        end
        rr_mode = 0;
        wait_idle();
        chk("rand_resp_count", n_pop - pop0, n_rd - rd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
